// File: rtl/gol_pkg.sv
// Shared constants and sequencer state type for the next-state flow.
package gol_pkg;

  localparam int unsigned GOL_ROWS       = 720;
  localparam int unsigned GOL_ROW_ADDR_W = 10;
  localparam int unsigned GOL_GEN_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_SWAP  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/generation_sequencer.sv
// Walks every board row per generation through the line buffer, drains the
// pipeline, swaps ping-pong banks, and repeats for a target or until stopped.
module generation_sequencer
  import gol_pkg::*;
#(
  parameter int unsigned ROWS       = GOL_ROWS,
  parameter int unsigned ROW_ADDR_W = GOL_ROW_ADDR_W,
  parameter int unsigned GEN_W      = GOL_GEN_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [GEN_W-1:0]      num_gens,
  input  logic                  stop,
  output logic                  busy,
  output logic                  done,
  output logic [GEN_W-1:0]      gen_count,
  output logic                  read_bank,
  output logic                  row_req,
  output logic [ROW_ADDR_W-1:0] calc_row,
  input  logic                  row_ack,
  input  logic                  pipe_idle
);

  localparam logic [ROW_ADDR_W-1:0] LAST_ROW = ROW_ADDR_W'(ROWS - 1);

  seq_state_e            state_q, state_d;
  logic [ROW_ADDR_W-1:0] calc_row_q, calc_row_d;
  logic [GEN_W-1:0]      gen_count_q, gen_count_d;
  logic [GEN_W-1:0]      target_q, target_d;
  logic                  stop_q, stop_d;
  logic                  bank_q, bank_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  row_req_q, row_req_d;
  logic [GEN_W-1:0]      gen_inc;

  assign gen_inc = gen_count_q + GEN_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      calc_row_q  <= '0;
      gen_count_q <= '0;
      target_q    <= '0;
      stop_q      <= 1'b0;
      bank_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      row_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      calc_row_q  <= calc_row_d;
      gen_count_q <= gen_count_d;
      target_q    <= target_d;
      stop_q      <= stop_d;
      bank_q      <= bank_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      row_req_q   <= row_req_d;
    end
  end

  // done is decided on entry to SWAP so it is registered and visible during SWAP;
  // a stop arriving in that same entry cycle still ends this generation.
  always_comb begin
    state_d     = state_q;
    calc_row_d  = calc_row_q;
    gen_count_d = gen_count_q;
    target_d    = target_q;
    stop_d      = stop_q;
    bank_d      = bank_q;
    done_d      = 1'b0;

    if (state_q != ST_IDLE && stop) begin
      stop_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          target_d    = num_gens;
          gen_count_d = '0;
          stop_d      = 1'b0;
          calc_row_d  = '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (row_ack) begin
          if (calc_row_q == LAST_ROW) begin
            state_d = ST_DRAIN;
          end else begin
            calc_row_d = calc_row_q + ROW_ADDR_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (pipe_idle) begin
          state_d     = ST_SWAP;
          gen_count_d = gen_inc;
          bank_d      = ~bank_q;
          done_d      = stop_q | stop | ((target_q != '0) && (gen_inc == target_q));
        end
      end
      ST_SWAP: begin
        if (done_q) begin
          state_d = ST_IDLE;
        end else begin
          calc_row_d = '0;
          state_d    = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d    = (state_d != ST_IDLE);
    row_req_d = (state_d == ST_ISSUE);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign gen_count = gen_count_q;
  assign read_bank = bank_q;
  assign row_req   = row_req_q;
  assign calc_row  = calc_row_q;

endmodule

// File: doc/generation_sequencer.md
# generation_sequencer

Parametrised successor to the single-pass row iterator in the next-state flow: sequences the line buffer / parallel next-state pipeline over every row of the board for a programmable number of generations. Handles ping-pong bank selection between generations, explicit row request/acknowledge with the line buffer, pipeline drain before bank swap, and graceful stop. Sits in the top level between control (start/stop from the host side) and the line buffer.

## Interface
Parameters:
- ROWS, 720, board rows per generation
- ROW_ADDR_W, 10, width of row index; must satisfy 2^ROW_ADDR_W >= ROWS
- GEN_W, 16, width of generation count/target

Ports:
- clk  in  1  single clock for the block (same domain as the line buffer)
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE
- num_gens  in  GEN_W  generations to compute, captured on accepted start; 0 = free-run until stop
- stop  in  1  request halt at end of current generation; latched while busy
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when run ends
- gen_count  out  GEN_W  generations completed in current/last run
- read_bank  out  1  source bank for fetches; write-back bank is ~read_bank
- row_req  out  1  row request to line buffer
- calc_row  out  ROW_ADDR_W  row being requested; stable while row_req high
- row_ack  in  1  line buffer has accepted calc_row
- pipe_idle  in  1  next-state pipeline and BRAM write-back fully drained

## Operation
- States: IDLE, ISSUE, DRAIN, SWAP.
- IDLE: busy=0, row_req=0. start=1 -> capture num_gens, clear gen_count and stop latch, calc_row=0 -> ISSUE.
- ISSUE: row_req=1. On row_ack: if calc_row==ROWS-1 -> DRAIN (row_req drops next cycle), else calc_row+1. No ack -> hold row_req and calc_row.
- DRAIN: row_req=0; wait for pipe_idle=1 -> SWAP.
- SWAP (exactly one cycle): read_bank toggles, gen_count+1 (wraps mod 2^GEN_W). If stop latched, or num_gens!=0 and new gen_count==num_gens_captured -> IDLE with done=1 that cycle; else calc_row=0 -> ISSUE.
- stop is latched in any non-IDLE state (including the SWAP cycle it arrives in -> applies to the following generation); stop in IDLE ignored.
- start while busy ignored; num_gens changes while busy ignored.
- read_bank is not reset by start: consecutive runs continue from the latest board.
- calc_row never exceeds ROWS-1; calc_row returns to 0 at every generation start.

## Timing
- Reset: busy=0, done=0, row_req=0, calc_row=0, gen_count=0, read_bank=0, state IDLE, stop latch cleared. Reset mid-run aborts immediately; no done pulse.
- start accepted at edge N -> busy=1 and row_req=1 visible after edge N.
- With row_ack held high: one row per cycle; ROWS cycles in ISSUE.
- Last ack -> DRAIN next cycle; pipe_idle already high -> SWAP the cycle after entering DRAIN (DRAIN minimum one cycle).
- Minimum generation period: ROWS + 2 cycles.
- done and busy fall together: done=1 in the SWAP cycle, busy=0 from the next cycle.
- pipe_idle is ignored outside DRAIN; row_ack ignored outside ISSUE.

## Structure
- Shared package gol_pkg: ROWS, ROW_ADDR_W default constants and the state enum (IDLE/ISSUE/DRAIN/SWAP) used by sequencer and debug logic.
- Single module: one FSM plus row counter, generation counter, captured target and stop latch; no sub-module warranted.

## Test plan
- ROWS=4, num_gens=2, row_ack and pipe_idle tied 1, start pulse -> calc_row 0,1,2,3,0,1,2,3; read_bank 0->1->0; gen_count 1 then 2; done one cycle; total busy = 12 cycles.
- ROWS=4, row_ack low 3 cycles on row 2 -> row_req and calc_row=2 held for those cycles; no row skipped or repeated.
- pipe_idle low 5 cycles after last ack -> state stays DRAIN 5 cycles, read_bank and gen_count unchanged until pipe_idle rises.
- num_gens=0, stop pulsed mid-gen 3 -> generation 3 completes, gen_count=3, done pulses, busy falls; read_bank = 1.
- start pulsed while busy and stop pulsed in IDLE -> both ignored; second run after done starts with read_bank from previous run, gen_count cleared.
- rst asserted during ISSUE at row 2 -> next cycle all outputs at reset values, no done; subsequent start runs normally from row 0.
